utf8_stream_decoder: RTL and testbench

- Clocked, streaming UTF-8 to code-point decoder. It is the successor to the strobe-driven byte/character converter.
- Accepts one byte per cycle over a valid/ready handshake and emits one code point per cycle with an error class.
- Parametrised for maximum sequence length (4 or 6), range checking, surrogate rejection and U+FFFD replacement.
- Sits between a byte-stream source (UART/DMA) and character-level consumers; handles truncated sequences and end-of-stream flush without host intervention.

---
 rtl/utf8_stream_decoder.sv | 245 ++++++++++++++++++++++++
 tb/tb_utf8_stream_decoder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/utf8_stream_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | utf8_stream_decoder: valid/ready UTF-8 byte stream to code-point decoder.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module utf8_stream_decoder #(
    parameter int MAX_LEN     = 4,
    parameter bit CHK_RANGE   = 1'b1,
    parameter bit REJECT_SURR = 1'b1,
    parameter bit REPLACE     = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_char,
    output logic [2:0]       out_err,
    output logic             out_last,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_FLUSH   = 2'd3;

    localparam logic [2:0] E_OK       = 3'd0;
    localparam logic [2:0] E_INVALID  = 3'd1;
    localparam logic [2:0] E_OVERLONG = 3'd2;
    localparam logic [2:0] E_TRUNC    = 3'd3;
    localparam logic [2:0] E_NONUNI   = 3'd4;
    localparam logic [2:0] E_SURR     = 3'd5;

    localparam logic [31:0] c_repl_char = 32'h0000_FFFD;
    localparam bit          c_long_ok   = (MAX_LEN == 6);

    logic [1:0]       r_state, w_state_nxt;
    logic [2:0]       r_rem, w_rem_nxt;
    logic [2:0]       r_len, w_len_nxt;
    logic [31:0]      r_acc, w_acc_nxt;
    logic [7:0]       r_lead, w_lead_nxt;
    logic [7:0]       r_hold_byte, w_hold_byte_nxt;
    logic             r_hold_last, w_hold_last_nxt;

    logic             r_out_valid;
    logic [31:0]      r_out_char;
    logic [2:0]       r_out_err;
    logic             r_out_last;
    logic [CNT_W-1:0] r_err_count;

    logic             w_out_free;
    logic             w_in_fire;
    logic [7:0]       w_byte;
    logic             w_blast;
    logic             w_fresh;
    logic             w_coll;
    logic             w_is_cont;
    logic             w_last_cont;
    logic [31:0]      w_acc_cont;
    logic [2:0]       w_lead_len;
    logic [31:0]      w_lead_pay;
    logic [31:0]      w_min;
    logic [2:0]       w_class;

    logic             w_load;
    logic [31:0]      w_load_raw;
    logic [2:0]       w_load_err;
    logic             w_load_last;

    assign w_out_free  = ~r_out_valid | out_ready;
    assign in_ready    = ((r_state == S_IDLE) | (r_state == S_COLLECT)) & w_out_free;
    assign w_in_fire   = in_valid & in_ready;

    // HOLD replays the latched byte through the same path as a fresh IDLE byte
    assign w_byte      = (r_state == S_HOLD) ? r_hold_byte : in_data;
    assign w_blast     = (r_state == S_HOLD) ? r_hold_last : in_last;
    assign w_fresh     = ((r_state == S_IDLE) & w_in_fire) | ((r_state == S_HOLD) & w_out_free);
    assign w_coll      = (r_state == S_COLLECT) & w_in_fire;
    assign w_is_cont   = (w_byte[7:6] == 2'b10);
    assign w_last_cont = (r_rem == 3'd1);
    assign w_acc_cont  = (r_acc << 6) | {26'd0, w_byte[5:0]};

    always_comb begin
        w_lead_len = 3'd0;
        w_lead_pay = 32'd0;
        if (w_byte[7:5] == 3'b110) begin
            w_lead_len = 3'd2;
            w_lead_pay = {27'd0, w_byte[4:0]};
        end else if (w_byte[7:4] == 4'b1110) begin
            w_lead_len = 3'd3;
            w_lead_pay = {28'd0, w_byte[3:0]};
        end else if (w_byte[7:3] == 5'b11110) begin
            w_lead_len = 3'd4;
            w_lead_pay = {29'd0, w_byte[2:0]};
        end else if (c_long_ok && (w_byte[7:2] == 6'b111110)) begin
            w_lead_len = 3'd5;
            w_lead_pay = {30'd0, w_byte[1:0]};
        end else if (c_long_ok && (w_byte[7:1] == 7'b1111110)) begin
            w_lead_len = 3'd6;
            w_lead_pay = {31'd0, w_byte[0]};
        end
    end

    always_comb begin
        case (r_len)
            3'd2:    w_min = 32'h0000_0080;
            3'd3:    w_min = 32'h0000_0800;
            3'd4:    w_min = 32'h0001_0000;
            3'd5:    w_min = 32'h0020_0000;
            default: w_min = 32'h0400_0000;
        endcase
        if (w_acc_cont < w_min) begin
            w_class = E_OVERLONG;
        end else if (CHK_RANGE && (w_acc_cont > 32'h0010_FFFF)) begin
            w_class = E_NONUNI;
        end else if (REJECT_SURR && (w_acc_cont >= 32'h0000_D800) && (w_acc_cont <= 32'h0000_DFFF)) begin
            w_class = E_SURR;
        end else begin
            w_class = E_OK;
        end
    end

    // State register and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rem       <= 3'd0;
            r_len       <= 3'd0;
            r_acc       <= 32'd0;
            r_lead      <= 8'd0;
            r_hold_byte <= 8'd0;
            r_hold_last <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_char  <= 32'd0;
            r_out_err   <= E_OK;
            r_out_last  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_len       <= w_len_nxt;
            r_acc       <= w_acc_nxt;
            r_lead      <= w_lead_nxt;
            r_hold_byte <= w_hold_byte_nxt;
            r_hold_last <= w_hold_last_nxt;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_char  <= (REPLACE && (w_load_err != E_OK)) ? c_repl_char : w_load_raw;
                r_out_err   <= w_load_err;
                r_out_last  <= w_load_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_out_valid && out_ready && (r_out_err != E_OK) && !(&r_err_count)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt     = r_state;
        w_rem_nxt       = r_rem;
        w_len_nxt       = r_len;
        w_acc_nxt       = r_acc;
        w_lead_nxt      = r_lead;
        w_hold_byte_nxt = r_hold_byte;
        w_hold_last_nxt = r_hold_last;
        if (w_fresh) begin
            w_state_nxt = S_IDLE;
            if (w_lead_len != 3'd0) begin
                w_lead_nxt  = w_byte;
                w_len_nxt   = w_lead_len;
                w_rem_nxt   = w_lead_len - 3'd1;
                w_acc_nxt   = w_lead_pay;
                w_state_nxt = w_blast ? S_FLUSH : S_COLLECT;
            end
        end else if (w_coll) begin
            if (!w_is_cont) begin
                w_hold_byte_nxt = in_data;
                w_hold_last_nxt = in_last;
                w_state_nxt     = S_HOLD;
            end else begin
                w_acc_nxt = w_acc_cont;
                w_rem_nxt = r_rem - 3'd1;
                if (w_last_cont) begin
                    w_state_nxt = S_IDLE;
                end else if (in_last) begin
                    w_state_nxt = S_FLUSH;
                end
            end
        end else if ((r_state == S_FLUSH) && w_out_free) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Output-register load selection
    always_comb begin
        w_load      = 1'b0;
        w_load_raw  = 32'd0;
        w_load_err  = E_OK;
        w_load_last = 1'b0;
        if (w_fresh) begin
            if (!w_byte[7]) begin
                w_load      = 1'b1;
                w_load_raw  = {24'd0, w_byte};
                w_load_last = w_blast;
            end else if (w_lead_len == 3'd0) begin
                w_load      = 1'b1;
                w_load_raw  = {{24{w_byte[7]}}, w_byte};
                w_load_err  = E_INVALID;
                w_load_last = w_blast;
            end
        end else if (w_coll) begin
            if (!w_is_cont) begin
                w_load     = 1'b1;
                w_load_raw = {{24{r_lead[7]}}, r_lead};
                w_load_err = E_TRUNC;
            end else if (w_last_cont) begin
                w_load      = 1'b1;
                w_load_raw  = w_acc_cont;
                w_load_err  = w_class;
                w_load_last = in_last;
            end
        end else if ((r_state == S_FLUSH) && w_out_free) begin
            w_load      = 1'b1;
            w_load_raw  = {{24{r_lead[7]}}, r_lead};
            w_load_err  = E_TRUNC;
            w_load_last = 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_char  = r_out_char;
    assign out_err   = r_out_err;
    assign out_last  = r_out_last;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_utf8_stream_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_utf8_stream_decoder: directed and random checks of two decoder configs. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_utf8_stream_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [2];
    logic [7:0]  in_data   [2];
    logic        in_last   [2];
    logic        out_ready [2];
    wire         in_ready_w  [2];
    wire         out_valid_w [2];
    wire [31:0]  out_char_w  [2];
    wire [2:0]   out_err_w   [2];
    wire         out_last_w  [2];
    wire [15:0]  err_count_w [2];

    int checks = 0;
    int errors = 0;
    int exp_errs [2];

    logic [7:0]  sq [$];
    bit          lq [$];
    logic [31:0] ec [$];
    logic [2:0]  ee [$];
    bit          el [$];

    always #5 clk = ~clk;

    // Instance 0: 4-byte limit, range check, replacement on
    utf8_stream_decoder #(.MAX_LEN(4), .CHK_RANGE(1'b1), .REJECT_SURR(1'b1), .REPLACE(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]), .in_data(in_data[0]),
        .in_last(in_last[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready[0]), .out_char(out_char_w[0]),
        .out_err(out_err_w[0]), .out_last(out_last_w[0]), .err_count(err_count_w[0]));

    // Instance 1: 6-byte leads, no range check, raw values on error
    utf8_stream_decoder #(.MAX_LEN(6), .CHK_RANGE(1'b0), .REJECT_SURR(1'b1), .REPLACE(1'b0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]), .in_data(in_data[1]),
        .in_last(in_last[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready[1]), .out_char(out_char_w[1]),
        .out_err(out_err_w[1]), .out_last(out_last_w[1]), .err_count(err_count_w[1]));

    function automatic int p_ml(input int k);
        return (k == 0) ? 4 : 6;
    endfunction
    function automatic bit p_chk(input int k);
        return (k == 0);
    endfunction
    function automatic bit p_rep(input int k);
        return (k == 0);
    endfunction

    function automatic logic [31:0] sext(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        sq.delete(); lq.delete(); ec.delete(); ee.delete(); el.delete();
    endtask

    task automatic load(input logic [7:0] b, input bit l);
        sq.push_back(b);
        lq.push_back(l);
    endtask

    task automatic push(input int k, input logic [31:0] raw, input int err, input bit l);
        ec.push_back((p_rep(k) && err != 0) ? 32'h0000FFFD : raw);
        ee.push_back(err[2:0]);
        el.push_back(l);
        if (err != 0) exp_errs[k]++;
    endtask

    // Reference decoder: walks the whole byte list with lookahead
    function automatic int lead_len(input int k, input logic [7:0] b);
        if (b >= 8'hC0 && b <= 8'hDF) return 2;
        if (b >= 8'hE0 && b <= 8'hEF) return 3;
        if (b >= 8'hF0 && b <= 8'hF7) return 4;
        if (p_ml(k) == 6 && b >= 8'hF8 && b <= 8'hFB) return 5;
        if (p_ml(k) == 6 && b >= 8'hFC && b <= 8'hFD) return 6;
        return 0;
    endfunction

    function automatic int classify(input int k, input longint v, input int len);
        longint mins [7] = '{0, 0, 'h80, 'h800, 'h10000, 'h200000, 'h4000000};
        if (v < mins[len]) return 2;
        if (p_chk(k) && v > 'h10FFFF) return 4;
        if (v >= 'hD800 && v <= 'hDFFF) return 5;
        return 0;
    endfunction

    task automatic model(input int k);
        int i, n, len, j;
        bit fin;
        longint v;
        logic [7:0] b, c;
        i = 0;
        n = sq.size();
        while (i < n) begin
            b = sq[i];
            len = lead_len(k, b);
            if (b < 8'h80) begin
                push(k, {24'd0, b}, 0, lq[i]); i++;
            end else if (len == 0) begin
                push(k, sext(b), 1, lq[i]); i++;
            end else if (lq[i]) begin
                push(k, sext(b), 3, 1); i++;
            end else begin
                v = longint'(b) & ((64'd1 << (7 - len)) - 1);
                j = 1;
                fin = 0;
                while (!fin) begin
                    if (i + j >= n) begin
                        i = n; fin = 1;
                    end else begin
                        c = sq[i + j];
                        if (c[7:6] != 2'b10) begin
                            push(k, sext(b), 3, 0); i = i + j; fin = 1;
                        end else begin
                            v = v * 64 + longint'(c[5:0]);
                            if (j == len - 1) begin
                                push(k, v[31:0], classify(k, v, len), lq[i + j]); i = i + j + 1; fin = 1;
                            end else if (lq[i + j]) begin
                                push(k, sext(b), 3, 1); i = i + j + 1; fin = 1;
                            end else begin
                                j++;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic add_rand(input logic [7:0] b);
        load(b, $urandom_range(0, 24) == 0);
    endtask

    task automatic gen_random(input int ntok);
        int r, len, nb;
        longint v;
        logic [7:0] pfx [7] = '{8'h00, 8'h00, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC};
        for (int t = 0; t < ntok; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                add_rand(8'($urandom_range(0, 127)));
            end else if (r <= 7) begin
                len = $urandom_range(2, 6);
                nb = (7 - len) + 6 * (len - 1);
                v = longint'($urandom) & ((64'd1 << nb) - 1);
                if ($urandom_range(0, 3) == 0) v = v & 64'h7FF;
                add_rand(pfx[len] | 8'(v >> (6 * (len - 1))));
                for (int j = 1; j < len - ((r == 7) ? 1 : 0); j++)
                    add_rand(8'h80 | 8'((v >> (6 * (len - 1 - j))) & 63));
            end else if (r == 8) begin
                add_rand(8'($urandom_range(0, 255)));
            end else begin
                add_rand(8'hED);
                add_rand(8'h80 | 8'($urandom_range(0, 63)));
                add_rand(8'h80 | 8'($urandom_range(0, 63)));
            end
        end
        lq[lq.size() - 1] = 1'b1;
    endtask

    // Drives sq into instance k and scores outputs against ec/ee/el; entered and left at posedge+1
    task automatic run(input int k, input int rdy_pct, input bit gaps, input string tag, output int stalls);
        int ptr, budget, limit;
        bit prev_hold;
        logic [31:0] prev_char;
        logic [2:0] prev_err;
        ptr = 0; budget = 0; stalls = 0; prev_hold = 0; prev_char = 0; prev_err = 0;
        limit = 40 * sq.size() + 100;
        while ((ptr < sq.size() || ec.size() > 0) && budget < limit) begin
            if (ptr < sq.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
                in_valid[k] = 1'b1; in_data[k] = sq[ptr]; in_last[k] = lq[ptr];
            end else begin
                in_valid[k] = 1'b0; in_data[k] = 8'h00; in_last[k] = 1'b0;
            end
            out_ready[k] = ($urandom_range(0, 99) < rdy_pct);
            @(negedge clk);
            if (prev_hold) begin
                chk({tag, "_held_valid"}, out_valid_w[k], 1);
                chk({tag, "_held_char"}, out_char_w[k], prev_char);
                chk({tag, "_held_err"}, out_err_w[k], prev_err);
            end
            if (out_valid_w[k] && out_ready[k]) begin
                if (ec.size() == 0) begin
                    chk({tag, "_extra_output"}, out_valid_w[k], 0);
                end else begin
                    chk({tag, "_char"}, out_char_w[k], ec.pop_front());
                    chk({tag, "_err"}, out_err_w[k], ee.pop_front());
                    chk({tag, "_last"}, out_last_w[k], el.pop_front());
                end
            end
            if (in_valid[k]) begin
                if (in_ready_w[k]) ptr++;
                else stalls++;
            end
            prev_hold = out_valid_w[k] && !out_ready[k];
            prev_char = out_char_w[k];
            prev_err = out_err_w[k];
            @(posedge clk); #1;
            budget++;
        end
        chk({tag, "_within_budget"}, budget < limit, 1);
        in_valid[k] = 1'b0; in_last[k] = 1'b0; out_ready[k] = 1'b1;
        @(negedge clk);
        chk({tag, "_quiet_after"}, out_valid_w[k], 0);
        @(posedge clk); #1;
    endtask

    task automatic stall_test(input int k);
        logic [7:0] seq [3] = '{8'hED, 8'hA0, 8'h80};
        bit got;
        for (int i = 0; i < 3; i++) begin
            in_valid[k] = 1'b1; in_data[k] = seq[i]; in_last[k] = 1'b0; out_ready[k] = 1'b0;
            @(negedge clk);
            chk("stall_accept", in_ready_w[k], 1);
            @(posedge clk); #1;
        end
        in_data[k] = 8'hC3; in_last[k] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready_w[k], 0);
            chk("stall_valid", out_valid_w[k], 1);
            chk("stall_char", out_char_w[k], p_rep(k) ? 32'h0000FFFD : 32'h0000D800);
            chk("stall_err", out_err_w[k], 5);
            @(posedge clk); #1;
        end
        out_ready[k] = 1'b1;
        @(negedge clk);
        chk("drain_in_ready", in_ready_w[k], 1);
        chk("drain_last", out_last_w[k], 0);
        @(posedge clk); #1;
        in_valid[k] = 1'b0; in_last[k] = 1'b0;
        got = 0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (out_valid_w[k]) begin
                got = 1;
                chk("flush_char", out_char_w[k], p_rep(k) ? 32'h0000FFFD : 32'hFFFFFFC3);
                chk("flush_err", out_err_w[k], 3);
                chk("flush_last", out_last_w[k], 1);
            end
            @(posedge clk); #1;
        end
        chk("flush_seen", got, 1);
        exp_errs[k] += 2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_data[k] = 8'h00; in_last[k] = 1'b0; out_ready[k] = 1'b1;
            exp_errs[k] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", out_valid_w[k], 0);
            chk("rst_out_char", out_char_w[k], 0);
            chk("rst_out_err", out_err_w[k], 0);
            chk("rst_out_last", out_last_w[k], 0);
            chk("rst_err_count", err_count_w[k], 0);
            chk("rst_in_ready", in_ready_w[k], 1);
        end
        @(posedge clk); #1;

        for (int k = 0; k < 2; k++) begin
            // Well-formed 1..4 byte characters at full rate
            clear_q();
            load(8'h41, 0); load(8'h42, 0); load(8'h43, 0);
            load(8'hC3, 0); load(8'hA9, 0);
            load(8'hE2, 0); load(8'h82, 0); load(8'hAC, 0);
            load(8'hF0, 0); load(8'h9F, 0); load(8'h98, 0); load(8'h80, 1);
            push(k, 32'h41, 0, 0); push(k, 32'h42, 0, 0); push(k, 32'h43, 0, 0);
            push(k, 32'hE9, 0, 0); push(k, 32'h20AC, 0, 0); push(k, 32'h1F600, 0, 1);
            run(k, 100, 0, "valid", st);
            chk("valid_no_stall", st, 0);
            chk("valid_err_count", err_count_w[k], exp_errs[k]);

            // Overlong forms
            clear_q();
            load(8'hC0, 0); load(8'hAF, 0); load(8'hE0, 0); load(8'h80, 0); load(8'h80, 1);
            push(k, 32'h2F, 2, 0); push(k, 32'h0, 2, 1);
            run(k, 100, 0, "overlong", st);
            chk("overlong_err_count", err_count_w[k], 2);

            // Truncation by a non-continuation byte costs one input stall
            clear_q();
            load(8'hE2, 0); load(8'h82, 0); load(8'h41, 0); load(8'h42, 1);
            push(k, 32'hFFFFFFE2, 3, 0); push(k, 32'h41, 0, 0); push(k, 32'h42, 0, 1);
            run(k, 100, 0, "trunc", st);
            chk("trunc_hold_stall", st, 1);

            // Above U+10FFFF, then a 6-byte form
            clear_q();
            load(8'hF4, 0); load(8'h90, 0); load(8'h80, 0); load(8'h80, 1);
            push(k, 32'h110000, p_chk(k) ? 4 : 0, 1);
            load(8'hFC, 0); load(8'h84, 0); load(8'h80, 0); load(8'h80, 0); load(8'h80, 0); load(8'h80, 1);
            if (p_ml(k) == 6) begin
                push(k, 32'h4000000, 0, 1);
            end else begin
                push(k, 32'hFFFFFFFC, 1, 0); push(k, 32'hFFFFFF84, 1, 0);
                for (int i = 0; i < 3; i++) push(k, 32'hFFFFFF80, 1, 0);
                push(k, 32'hFFFFFF80, 1, 1);
            end
            run(k, 100, 0, "range_long", st);

            // Surrogate held under back-pressure, then a truncated tail flush
            stall_test(k);
            chk("stall_err_count", err_count_w[k], exp_errs[k]);

            // Random streams against the reference decoder
            for (int ph = 0; ph < 3; ph++) begin
                clear_q();
                gen_random(50);
                model(k);
                run(k, (ph == 0) ? 100 : ((ph == 1) ? 60 : 30), ph != 0, "random", st);
                chk("random_err_count", err_count_w[k], exp_errs[k]);
            end

            // Reset in the middle of a sequence drops it silently
            clear_q();
            load(8'hE2, 0); load(8'h82, 0);
            run(k, 100, 0, "pre_reset", st);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            exp_errs[0] = 0; exp_errs[1] = 0;
            @(negedge clk);
            chk("midrst_out_valid", out_valid_w[k], 0);
            chk("midrst_err_count", err_count_w[k], 0);
            @(posedge clk); #1;
            clear_q();
            load(8'h41, 1);
            push(k, 32'h41, 0, 1);
            run(k, 100, 0, "post_reset", st);
            chk("post_reset_err_count", err_count_w[k], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
